// File: rtl/acc_cpu_core.sv
// ---------------------------------------------------------------------------
// acc_cpu_core -- parametrised accumulator CPU with a req/ack memory port.
//
// Parameters
//   DW  : data / accumulator / instruction word width
//   AW  : address width (PC, operand address, mem_addr)
//   OPW : opcode field width (AW+OPW must not exceed DW)
//
// Ports
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   mem_req    memory access request (held until mem_ack)
//   mem_we     1 = write, 0 = read, valid while mem_req=1
//   mem_addr   access address, valid while mem_req=1
//   mem_wdata  write data, always the accumulator
//   mem_rdata  read data, sampled only in an ack cycle
//   mem_ack    completes the access in the cycle it is high with mem_req
//   pc_out     current program counter
//   acc_out    current accumulator
//   zflag      accumulator is zero (combinational)
//   cflag      registered carry/borrow from ADD/SUB
//   halted     core sits in HALT
//   illegal    sticky, an undefined opcode was decoded
//
// Instruction word: opcode = IR[OPW-1:0], operand address = IR[DW-1 -: AW].
// ---------------------------------------------------------------------------
module acc_cpu_core #(
    parameter int DW  = 16,
    parameter int AW  = 8,
    parameter int OPW = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] acc_out,
    output logic          zflag,
    output logic          cflag,
    output logic          halted,
    output logic          illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM_RD = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_HALT  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(2);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(3);
    localparam logic [OPW-1:0] OP_JUMPZ = OPW'(4);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(5);
    localparam logic [OPW-1:0] OP_STORE = OPW'(6);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(7);
    localparam logic [OPW-1:0] OP_AND   = OPW'(8);
    localparam logic [OPW-1:0] OP_JUMPC = OPW'(9);
    localparam logic [OPW-1:0] OP_LOADI = OPW'(10);

    state_t          state_r;
    logic [AW-1:0]   pc_r;
    logic [DW-1:0]   ir_r;
    logic [DW-1:0]   acc_r;
    logic [DW-1:0]   mdr_r;
    logic            cflag_r;
    logic            illegal_r;

    logic [OPW-1:0]  op_s;
    logic [AW-1:0]   addr_s;
    logic            zflag_s;
    logic [DW:0]     sum_s;
    logic            borrow_s;
    logic            access_s;
    logic            write_s;

    assign op_s     = ir_r[OPW-1:0];
    assign addr_s   = ir_r[DW-1 -: AW];
    assign zflag_s  = (acc_r == {DW{1'b0}});
    assign sum_s    = {1'b0, acc_r} + {1'b0, mdr_r};
    assign borrow_s = (acc_r < mdr_r);

    // Memory access decode from the current state.
    always_comb begin
        access_s = 1'b0;
        write_s  = 1'b0;
        case (state_r)
            S_FETCH:  access_s = 1'b1;
            S_MEM_RD: access_s = 1'b1;
            S_MEM_WR: begin
                access_s = 1'b1;
                write_s  = 1'b1;
            end
            default: begin
                access_s = 1'b0;
                write_s  = 1'b0;
            end
        endcase
    end

    // The reset input gates the request so it drops at once, without a clock,
    // even though the state register resets into FETCH.
    assign mem_req   = access_s & rst;
    assign mem_we    = write_s & rst;
    assign mem_addr  = (state_r == S_FETCH) ? pc_r : addr_s;
    assign mem_wdata = acc_r;
    assign pc_out    = pc_r;
    assign acc_out   = acc_r;
    assign zflag     = zflag_s;
    assign cflag     = cflag_r;
    assign halted    = (state_r == S_HALT);
    assign illegal   = illegal_r;

    // Main control FSM together with the architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= S_FETCH;
            pc_r      <= {AW{1'b0}};
            ir_r      <= {DW{1'b0}};
            acc_r     <= {DW{1'b0}};
            mdr_r     <= {DW{1'b0}};
            cflag_r   <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_r    <= mem_rdata;
                        pc_r    <= pc_r + AW'(1);
                        state_r <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_s)
                        OP_HALT:  state_r <= S_HALT;
                        OP_JUMP: begin
                            pc_r    <= addr_s;
                            state_r <= S_FETCH;
                        end
                        OP_JUMPZ: begin
                            if (zflag_s) begin
                                pc_r <= addr_s;
                            end
                            state_r <= S_FETCH;
                        end
                        OP_JUMPC: begin
                            if (cflag_r) begin
                                pc_r <= addr_s;
                            end
                            state_r <= S_FETCH;
                        end
                        OP_LOADI: begin
                            acc_r   <= DW'(addr_s);
                            state_r <= S_FETCH;
                        end
                        OP_ADD, OP_XOR, OP_SUB, OP_AND, OP_LOAD: state_r <= S_MEM_RD;
                        OP_STORE: state_r <= S_MEM_WR;
                        default: begin
                            illegal_r <= 1'b1;
                            state_r   <= S_HALT;
                        end
                    endcase
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        mdr_r   <= mem_rdata;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_s)
                        OP_ADD: {cflag_r, acc_r} <= sum_s;
                        OP_SUB: begin
                            acc_r   <= acc_r - mdr_r;
                            cflag_r <= borrow_s;
                        end
                        OP_XOR:  acc_r <= acc_r ^ mdr_r;
                        OP_AND:  acc_r <= acc_r & mdr_r;
                        OP_LOAD: acc_r <= mdr_r;
                        default: acc_r <= acc_r;
                    endcase
                    state_r <= S_FETCH;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        state_r <= S_FETCH;
                    end
                end
                S_HALT:  state_r <= S_HALT;
                default: state_r <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised successor of the team's 16-bit accumulator CPU.
- Data width, address width and opcode-field width are generics.
- Memory is reached through a req/ack handshake, so it may take any number of wait states.
- Adds a carry flag, JUMPC, LOADI, an illegal-opcode trap and status outputs. It sits between the program/data RAM and the system top.

Parameters:
DW, 16, data, accumulator and instruction word width
AW, 8, address width (PC, operand address, mem_addr)
OPW, 8, opcode field width; legal only when AW+OPW <= DW

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_req  output  1  memory access request
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  output  AW  access address; valid while mem_req=1
mem_wdata  output  DW  write data; always equals ACC
mem_rdata  input  DW  read data; sampled only in an ack cycle
mem_ack  input  1  completes the access in the same cycle it is high together with mem_req
pc_out  output  AW  current PC
acc_out  output  DW  current ACC
zflag  output  1  combinational, (ACC == 0)
cflag  output  1  registered carry/borrow
halted  output  1  high in HALT state
illegal  output  1  sticky; set when an undefined opcode is decoded

Behaviour:
- Instruction format:
  - opcode = IR[OPW-1:0]
  - addr field = IR[DW-1:DW-AW]
  - unused middle bits are ignored.
- Opcodes:
  - 0 HALT, 1 ADD, 2 XOR, 3 JUMP, 4 JUMPZ, 5 LOAD, 6 STORE, 7 SUB, 8 AND, 9 JUMPC, 10 LOADI.
  - Every other opcode is illegal.
- Reset (rst=0, asynchronous):
  - PC=0, IR=0, ACC=0, MDR=0, cflag=0, illegal=0.
  - State = FETCH, mem_req=0, halted=0.
  - Takes effect mid-access: an outstanding request is dropped, and an ack arriving during reset is ignored.
- Handshake:
  - mem_req, mem_we and mem_addr are registered-state decodes and stay stable until an ack.
  - mem_ack while mem_req=0 is ignored.
  - Any number of wait cycles is allowed. There is no timeout.
- States and transitions:
  - FETCH: req=1, we=0, addr=PC. On ack: IR<=mem_rdata, PC<=PC+1 mod 2^AW (0xFF wraps to 0x00), go to DECODE. Without ack: stay.
  - DECODE: no memory access.
    - HALT goes to HALT.
    - Illegal opcode sets illegal=1 and goes to HALT.
    - JUMP: PC<=addr, go to FETCH.
    - JUMPZ: if zflag then PC<=addr; go to FETCH.
    - JUMPC: if cflag then PC<=addr; go to FETCH.
    - LOADI: ACC<=zero-extended addr; go to FETCH.
    - ADD, XOR, SUB, AND, LOAD go to MEM_RD.
    - STORE goes to MEM_WR.
  - MEM_RD: req=1, we=0, addr=addr field. On ack: MDR<=mem_rdata, go to EXEC.
  - EXEC: update ACC, then go to FETCH.
    - ADD: {c,ACC} <= ACC+MDR (DW+1-bit sum); cflag<=carry out.
    - SUB: ACC <= ACC−MDR mod 2^DW; cflag <= (ACC < MDR) unsigned borrow.
    - XOR, AND: bitwise; cflag unchanged.
    - LOAD: ACC<=MDR; cflag unchanged.
  - MEM_WR: req=1, we=1, addr=addr field, wdata=ACC. On ack: go to FETCH.
  - HALT: req=0, halted=1. Only reset leaves this state.
- Flags:
  - zflag reflects the current ACC register, so the JUMPZ decision uses ACC as it stands at DECODE.
  - cflag is written only by ADD and SUB.
- Latency with zero-wait memory (ack tied high): JUMP/JUMPZ/JUMPC/LOADI = 2 cycles, STORE = 3, ADD/XOR/SUB/AND/LOAD = 4. Each wait cycle on an access adds 1.
- Program memory and data memory share one address space, so self-modifying stores are permitted.

Test Plan:
- Zero-wait memory, DW=16/AW=8. Program: LOAD 0x10 (=5); ADD 0x11 (=7); STORE 0x12; HALT. Required: mem[0x12]=12, halted=1 after 4+4+3+2=13 cycles, pc_out=4, cflag=0.
- Carry and JUMPC: ACC=0xFFFF, ADD with MDR=0x0002. Required: ACC=0x0001, cflag=1. A following JUMPC 0x20 fetches next from 0x20.
- Borrow and JUMPZ: SUB 5−5 gives ACC=0, zflag=1, cflag=0; JUMPZ 0x30 is taken. SUB 3−5 gives ACC=0xFFFE, cflag=1; JUMPZ is not taken and PC advances by 1.
- Wait states: ack delayed 3 cycles on every access. Required: mem_req/mem_addr held stable throughout; ADD takes 10 cycles; results identical to the zero-wait run.
- Illegal and wrap-around:
  - Opcode 0x2A → illegal=1, halted=1, mem_req stays 0.
  - PC=0xFF fetching a non-jump instruction → pc_out=0x00.
- Reset mid-operation: rst low while MEM_WR is waiting for ack. Required: mem_req drops immediately (no clock needed), all registers are 0, and execution restarts by fetching from address 0 after rst rises.
- Parameter sweep: DW=32, AW=12, OPW=8. LOADI 0xABC gives ACC=0x00000ABC; an ADD overflow sets cflag.
